// File: rtl/seq_mux_rr_if.sv
// Handshake bundle for seq_mux_rr: per-channel input lanes, mode/select and the registered output.
// The out_par signal exists only when SEQ_MUX_PARITY_EN is defined.
interface seq_mux_rr_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SELW  = 2
);
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_valid;
   logic                 out_ready;
`ifdef SEQ_MUX_PARITY_EN
   logic                 out_par;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid, out_par
   );
   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_ch, out_valid, out_par
   );
`else
   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );
   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );
`endif
endinterface

// File: rtl/seq_mux_rr.sv
// Registered NCH:1 mux with valid/ready on every lane; fixed-select or round-robin arbitration.
// Optional even-parity output register enabled by SEQ_MUX_PARITY_EN.
module seq_mux_rr #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SELW  = 2
) (
   input logic         clk,
   input logic         rst_n,
   seq_mux_rr_if.slave bus
);
   typedef enum logic {StEmpty, StFull} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SELW-1:0]  ch_q, ch_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic             gnt_vld;
   logic [SELW-1:0]  gnt_idx;
   logic [WIDTH-1:0] gnt_data;
   logic             load;
   logic             xfer;
   logic [NCH-1:0]   one_hot;

   // Grant: reverse scan so the candidate closest to ptr is written last and wins.
   always_comb begin
      int unsigned     idx;
      logic [SELW-1:0] idx_s;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      idx_s   = '0;
      if (!bus.mode) begin
         if (32'(bus.sel) < NCH) begin
            if (bus.in_valid[bus.sel]) begin
               gnt_vld = 1'b1;
               gnt_idx = bus.sel;
            end
         end
      end else begin
         for (int i = int'(NCH) - 1; i >= 0; i--) begin
            idx = 32'(ptr_q) + 32'(i);
            if (idx >= NCH) idx = idx - NCH;
            idx_s = SELW'(idx);
            if (bus.in_valid[idx_s]) begin
               gnt_vld = 1'b1;
               gnt_idx = idx_s;
            end
         end
      end
   end

   assign gnt_data = bus.in_data[32'(gnt_idx)*WIDTH +: WIDTH];
   assign load     = (state_q == StEmpty) | bus.out_ready;
   assign xfer     = load & gnt_vld;

   always_comb begin
      one_hot = '0;
      one_hot[gnt_idx] = 1'b1;
   end

   // Reset gates in_ready: an empty register would otherwise advertise load during reset.
   assign bus.in_ready = (xfer && rst_n) ? one_hot : '0;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StEmpty: if (xfer) state_d = StFull;
         StFull:  if (bus.out_ready && !gnt_vld) state_d = StEmpty;
         default: state_d = StEmpty;
      endcase
      if (xfer) begin
         data_d = gnt_data;
         ch_d   = gnt_idx;
         if (bus.mode) begin
            ptr_d = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.out_valid = (state_q == StFull);
   assign bus.out_data  = data_q;
   assign bus.out_ch    = ch_q;

`ifdef SEQ_MUX_PARITY_EN
   logic par_q, par_d;

   assign par_d = xfer ? ^gnt_data : par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end

   assign bus.out_par = par_q;
`endif
endmodule

// File: tb/tb_seq_mux_rr.sv
// Directed self-checking bench for seq_mux_rr (WIDTH=8, NCH=4); parity steps need SEQ_MUX_PARITY_EN.
module tb_seq_mux_rr;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   seq_mux_rr_if #(.WIDTH(8), .NCH(4), .SELW(2)) bus ();

   seq_mux_rr #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] hold_data;
      checks   = 0;
      failures = 0;

      // Reset with random inputs
      rst_n         = 1'b0;
      bus.in_data   = {$urandom, $urandom};
      bus.in_valid  = 4'($urandom);
      bus.mode      = 1'($urandom);
      bus.sel       = 2'($urandom);
      bus.out_ready = 1'($urandom);
      #2;
      check("rst_valid", 32'(bus.out_valid), 32'h0);
      check("rst_data", 32'(bus.out_data), 32'h0);
      check("rst_ch", 32'(bus.out_ch), 32'h0);
      check("rst_in_ready", 32'(bus.in_ready), 32'h0);
      bus.in_valid  = 4'hF;
      bus.out_ready = 1'b1;
      repeat (2) tick();
      check("rst_hold_valid", 32'(bus.out_valid), 32'h0);
      check("rst_hold_in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fixed mode, sel=2
      bus.mode      = 1'b0;
      bus.sel       = 2'd2;
      bus.in_valid  = 4'b0100;
      bus.in_data   = {8'h13, 8'hA5, 8'h11, 8'h10};
      bus.out_ready = 1'b1;
      #1;
      check("fix_in_ready", 32'(bus.in_ready), 32'b0100);
      tick();
      check("fix_data", 32'(bus.out_data), 32'hA5);
      check("fix_ch", 32'(bus.out_ch), 32'd2);
      check("fix_valid", 32'(bus.out_valid), 32'h1);
      bus.in_valid = 4'b0000;
      tick();
      check("nogrant_valid", 32'(bus.out_valid), 32'h0);
      check("nogrant_data_hold", 32'(bus.out_data), 32'hA5);

      // Round-robin over all lanes, one word per clock
      bus.mode     = 1'b1;
      bus.in_valid = 4'b1111;
      bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      #1;
      for (int n = 0; n < 6; n++) begin
         check("rr_in_ready", 32'(bus.in_ready), 32'h1 << (n % 4));
         tick();
         check("rr_ch", 32'(bus.out_ch), 32'(n % 4));
         check("rr_data", 32'(bus.out_data), 32'h10 + 32'(n % 4));
         check("rr_valid", 32'(bus.out_valid), 32'h1);
      end

      // Backpressure: ptr=2, load 3C from lane 2 then stall
      bus.in_data = {8'h13, 8'h3C, 8'h11, 8'h10};
      #1;
      check("bp_load_ready", 32'(bus.in_ready), 32'b0100);
      tick();
      check("bp_load_data", 32'(bus.out_data), 32'h3C);
      bus.out_ready = 1'b0;
      #1;
      for (int n = 0; n < 5; n++) begin
         check("bp_in_ready", 32'(bus.in_ready), 32'h0);
         tick();
         check("bp_data", 32'(bus.out_data), 32'h3C);
         check("bp_ch", 32'(bus.out_ch), 32'd2);
         check("bp_valid", 32'(bus.out_valid), 32'h1);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.in_ready), 32'b1000);
      tick();
      check("bp_release_data", 32'(bus.out_data), 32'h13);
      check("bp_release_ch", 32'(bus.out_ch), 32'd3);

      // Skip and wrap: ptr=0 -> take lane 2 (ptr=3), then lane 1 (ptr=2), then lane 0 (wrap)
      bus.in_valid = 4'b0100;
      #1;
      check("skip_pre_ready", 32'(bus.in_ready), 32'b0100);
      tick();
      check("skip_pre_ch", 32'(bus.out_ch), 32'd2);
      bus.in_valid = 4'b0010;
      #1;
      check("skip_ready", 32'(bus.in_ready), 32'b0010);
      tick();
      check("skip_ch", 32'(bus.out_ch), 32'd1);
      check("skip_data", 32'(bus.out_data), 32'h11);
      bus.in_valid = 4'b0001;
      #1;
      check("wrap_ready", 32'(bus.in_ready), 32'b0001);
      tick();
      check("wrap_ch", 32'(bus.out_ch), 32'd0);
      check("wrap_data", 32'(bus.out_data), 32'h10);
      hold_data = 8'h10;

`ifdef SEQ_MUX_PARITY_EN
      bus.mode     = 1'b0;
      bus.sel      = 2'd0;
      bus.in_valid = 4'b0001;
      bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h07};
      tick();
      check("par_07", 32'(bus.out_par), 32'h1);
      bus.in_data = {8'h13, 8'h12, 8'h11, 8'h03};
      tick();
      check("par_03", 32'(bus.out_par), 32'h0);
      hold_data = 8'h03;
`endif

      // Fixed mode, sel=3 with lane 3 idle: drain then empty
      bus.mode     = 1'b0;
      bus.sel      = 2'd3;
      bus.in_valid = 4'b0111;
      #1;
      check("sel_idle_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("sel_idle_valid", 32'(bus.out_valid), 32'h0);
      check("sel_idle_data_hold", 32'(bus.out_data), 32'(hold_data));

      // Asynchronous reset while a word is held
      bus.sel      = 2'd1;
      bus.in_valid = 4'b0010;
      tick();
      check("pre_async_data", 32'(bus.out_data), 32'h11);
      bus.out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(bus.out_valid), 32'h0);
      check("async_data", 32'(bus.out_data), 32'h0);
      check("async_ch", 32'(bus.out_ch), 32'h0);
      check("async_in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
